pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 90 +++++++++
 tb/tb_pipe_stage_reg.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register between decode and execute.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build (registered in_ready).
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              accept, issue;

    assign out_valid = state_q != EMPTY;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready & !hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= CLEAR_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready = !hold & (state_q != FULL);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                main_d  = in_data;
            end
            ONE: begin
                if (accept & issue) main_d = in_data;
                else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (issue) state_d = EMPTY;
            end
            FULL: if (issue) begin
                state_d = ONE;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = CLEAR_VAL;
            skid_d  = CLEAR_VAL;
        end
    end

    always_ff @(posedge clk) skid_q <= reset ? CLEAR_VAL : skid_d;
`else
    assign in_ready = !hold & (!out_valid | out_ready);

    // an accept while occupied always coincides with an issue, so ONE is kept
    always_comb begin
        state_d = accept ? ONE : (issue ? EMPTY : state_q);
        main_d  = accept ? in_data : main_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = CLEAR_VAL;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed plus random stimulus against a queue-based model
// of pipe_stage_reg; follows PIPE_STAGE_SKID_EN to pick the expected capacity.
module tb_pipe_stage_reg;
    localparam int          W  = 32;
    localparam logic [W-1:0] CV = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, flush, hold;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;

    pipe_stage_reg #(.DATA_W(W), .CLEAR_VAL(CV)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .hold(hold), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] shadow = CV;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle: check outputs before the edge, then advance the model.
    task automatic step(input bit rst, input bit fl, input bit hd, input bit iv,
                        input logic [W-1:0] id, input bit ordy);
        bit ev, er;
        reset = rst; flush = fl; hold = hd; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        ev = q.size() != 0;
        er = !hd && (SKID ? q.size() < 2 : (!ev || ordy));
        chk("in_ready", W'(in_ready), W'(er));
        chk("out_valid", W'(out_valid), W'(ev));
        chk("out_data", out_data, ev ? q[0] : shadow);
        chk("occupancy", W'(occupancy), W'(q.size()));
        @(posedge clk);
        if (rst || fl) begin
            q.delete();
            shadow = CV;
        end else if (!hd) begin
            if (ev && ordy) shadow = q.pop_front();
            if (iv && er) q.push_back(id);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        // streaming at full throughput
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, W'(i), 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // backpressure then drain in order
        step(0, 0, 0, 1, 32'hA, 0);
        step(0, 0, 0, 1, 32'hB, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // flush while loaded, with a same-cycle offer that must vanish
        step(0, 0, 0, 1, 32'h1A, 0);
        step(0, 0, 0, 1, 32'h1B, 0);
        step(0, 1, 0, 1, 32'hC, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // hold freezes the stage for three cycles
        step(0, 0, 0, 1, 32'h55, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h66, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // reset dominates flush and hold while loaded
        step(0, 0, 0, 1, 32'h21, 0);
        step(0, 0, 0, 1, 32'h22, 0);
        step(1, 1, 1, 1, 32'h23, 1);
        step(0, 0, 0, 1, 32'h9, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // pass-through with combinational ready in the single-register build
        step(0, 0, 0, 1, 32'h5, 0);
        step(0, 0, 0, 1, 32'h7, 1);
        step(0, 0, 0, 1, 32'h8, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++)
            step($urandom % 64 == 0, $urandom % 32 == 0, $urandom % 5 == 0,
                 $urandom % 4 != 0, $urandom, $urandom % 3 != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
